// File: rtl/instruction_feeder_pkg.sv
// Constants shared by the instruction feeder and the processor it feeds:
// FIFO depth, NOP word, slot phase width and the feeder state encoding.
package instruction_feeder_pkg;
  localparam int unsigned FEED_DEPTH = 8;
  localparam int unsigned WORD_W     = 16;
  localparam int unsigned PHASE_W    = 2;
  localparam logic [WORD_W-1:0] FEED_NOP = 16'h0000;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } feed_state_e;
endpackage

// File: rtl/instruction_feeder_fifo.sv
// Instruction word FIFO: circular buffer with an explicit occupancy count so
// it can hold exactly DEPTH words. A push while full is accepted only when a
// pop frees a slot in the same cycle.
module instr_fifo
  import instruction_feeder_pkg::*;
#(
  parameter int unsigned DEPTH = FEED_DEPTH
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    push_i,
  input  logic [WORD_W-1:0]       data_i,
  input  logic                    pop_i,
  output logic [WORD_W-1:0]       data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: a zero count makes stale words unreachable.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/instruction_feeder.sv
// Feeds queued host instructions to the processor one per 4-cycle slot,
// changing iin only at the slot boundary (the edge where phase is 3).
module instruction_feeder
  import instruction_feeder_pkg::*;
#(
  parameter int unsigned       DEPTH = FEED_DEPTH,
  parameter logic [WORD_W-1:0] NOP   = FEED_NOP
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               wr_en,
  input  logic [WORD_W-1:0]  wr_data,
  input  logic               run,
  output logic [WORD_W-1:0]  iin,
  output logic               iin_valid,
  output logic [PHASE_W-1:0] phase,
  output logic               full,
  output logic               empty,
  output logic               overflow,
  output logic [7:0]         issued
);
  feed_state_e          state_q;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [WORD_W-1:0]    iin_q, head;
  logic [7:0]           issued_q;
  logic                 overflow_q, overflow_d;
  logic                 boundary, pop;
  logic [$clog2(DEPTH):0] fifo_count;

  assign phase_d  = phase_q + 1'b1;
  assign boundary = (phase_q == '1);
  // Pop decision uses registered occupancy, so a same-cycle write never bypasses.
  assign pop      = boundary && run && (fifo_count != '0);
  assign overflow_d = overflow_q || (wr_en && full && !pop);

  instr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .push_i  (wr_en),
    .data_i  (wr_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      iin_q    <= NOP;
      issued_q <= '0;
    end else if (boundary) begin
      if (pop) begin
        state_q  <= ISSUE;
        iin_q    <= head;
        issued_q <= issued_q + 8'd1;
      end else begin
        state_q  <= IDLE;
        iin_q    <= NOP;
      end
    end
  end

  assign iin       = iin_q;
  assign iin_valid = (state_q == ISSUE);
  assign phase     = phase_q;
  assign overflow  = overflow_q;
  assign issued    = issued_q;
endmodule

// File: doc/instruction_feeder.md
INSTRUCTION_FEEDER -- requirements
Module: instruction_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the instruction FIFO depth in words (power of two).
REQ-002 SHALL have parameter NOP, default 16'h0000, meaning the word driven on iin when no instruction is issued.
REQ-003 SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit, reset that is asynchronous and active-low.
REQ-005 SHALL have port wr_en, input, 1 bit, host write strobe.
REQ-006 SHALL have port wr_data, input, 16 bits, host instruction word.
REQ-007 SHALL have port run, input, 1 bit, issue enable (0 = hold off, issue NOP).
REQ-008 SHALL have port iin, output, 16 bits, instruction word presented to the processor.
REQ-009 SHALL have port iin_valid, output, 1 bit, 1 while iin carries a real (non-NOP) instruction.
REQ-010 SHALL have port phase, output, 2 bits, the current slot phase 0..3, aligned with the processor's phase counter.
REQ-011 SHALL have port full, output, 1 bit, FIFO holds DEPTH words.
REQ-012 SHALL have port empty, output, 1 bit, FIFO holds 0 words.
REQ-013 SHALL have port overflow, output, 1 bit, sticky flag for a write dropped while full.
REQ-014 SHALL have port issued, output, 8 bits, count of instructions issued, wrapping 255->0.

Function
REQ-015 SHALL free-run phase 0->1->2->3->0, one step per clock, regardless of run or FIFO state.
REQ-016 SHALL define the slot boundary as the clock edge at which phase is 3; iin/iin_valid change only at slot boundaries and hold stable for exactly 4 cycles (phases 0..3).
REQ-017 SHALL use states IDLE (iin=NOP, iin_valid=0) and ISSUE (iin=popped word, iin_valid=1); the next state is evaluated only at a slot boundary.
REQ-018 SHALL, at a slot boundary with run=1 and the FIFO not empty, pop the head into iin, set iin_valid=1, enter ISSUE and increment issued by 1 mod 256.
REQ-019 SHALL, at a slot boundary with run=0 or the FIFO empty, drive iin=NOP, iin_valid=0 and enter IDLE without popping.
REQ-020 SHALL accept wr_en=1 when not full, storing wr_data at the tail; occupancy is 0..DEPTH, with read/write pointers wrapping modulo DEPTH.
REQ-021 SHALL, on wr_en=1 while full and no pop in the same cycle, drop the word and set overflow=1.
REQ-022 SHALL, on a simultaneous write and pop when full, accept the write with no overflow and leave occupancy at DEPTH.
REQ-023 SHALL NOT bypass: a word written in the same cycle as a boundary with the FIFO empty is not issued at that boundary; it issues at the next boundary (minimum latency 1 cycle, maximum 4 cycles from write to iin).
REQ-024 SHALL derive full and empty combinationally from the occupancy count.
REQ-025 SHALL make a deassertion of run mid-slot take effect only at the next boundary; the current instruction completes its 4 cycles.

Reset
REQ-026 SHALL, on resetn=0 and asynchronously, set phase=0, state IDLE, iin=NOP, iin_valid=0, pointers and occupancy=0, empty=1, full=0, overflow=0 and issued=0.
REQ-027 SHALL discard FIFO contents on reset mid-operation; after release, the first possible issue is at the edge where phase is 3.

Structure
REQ-028 SHALL place DEPTH, NOP, the state encodings (IDLE=0, ISSUE=1) and the phase width in a shared constants include used by the feeder and the processor.
REQ-029 SHALL implement storage as one sub-module instr_fifo (push/pop/full/empty/count); the phase counter, FSM and issue logic remain in instruction_feeder.

Verification
REQ-030 SHALL cover: reset, run=1, write 16'hA123 at phase 1 -> iin=16'hA123, iin_valid=1 from the next phase 0 for 4 cycles, issued=1.
REQ-031 SHALL cover: write 16'h0001, 16'h0002, 16'h0003 back-to-back, run=1 -> issued on three consecutive slots, in order, then iin=NOP and iin_valid=0, empty=1.
REQ-032 SHALL cover: 9 writes with run=0 -> full=1 after 8 writes, 9th dropped, overflow=1; run=1 -> exactly the 8 first words issue.
REQ-033 SHALL cover: FIFO full, write during a pop boundary -> no overflow, full stays 1, new word issues 9th.
REQ-034 SHALL cover: run dropped at phase 1 of an ISSUE slot -> the current word is held through phase 3, then NOP; the FIFO head is not consumed.
REQ-035 SHALL cover: resetn pulsed low mid-slot with 3 words queued -> all outputs return to reset values immediately, empty=1, issued=0.
